// File: rtl/lane_dly_move_ctrl.sv
// lane_dly_move_ctrl: fabric-side initiator for one DDR4 lane-control delay line.
// It turns a "move N taps" / "load default code" request into pause-framed MOVE/LOAD
// pulses toward the lane, watches the selected out-of-range flag and reports completion.
//
// Handshake: a request is taken on a rising FAB_CLK edge where REQ_VALID && REQ_READY.
// REQ_READY is high only in IDLE. REQ_SEL/REQ_DIR/REQ_LOAD/REQ_STEPS are captured on that
// edge. REQ_VALID seen while busy is ignored, and the requester holds it until REQ_READY.
// DONE is a one-cycle pulse. DONE_STEPS/DONE_OOR are valid with DONE and held afterwards.
module lane_dly_move_ctrl #(
  parameter int PAUSE_SETUP = 4,
  parameter int MOVE_GAP    = 3,
  parameter int PAUSE_HOLD  = 4,
  parameter int STEP_W      = 8
) (
  input  logic              FAB_CLK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_SEL,
  input  logic              REQ_DIR,
  input  logic              REQ_LOAD,
  input  logic [STEP_W-1:0] REQ_STEPS,
  output logic              DELAY_LINE_SEL,
  output logic              DELAY_LINE_DIRECTION,
  output logic              DELAY_LINE_MOVE,
  output logic              DELAY_LINE_LOAD,
  output logic              HS_IO_CLK_PAUSE,
  input  logic              RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic              TX_DELAY_LINE_OUT_OF_RANGE,
  output logic              DONE,
  output logic [STEP_W-1:0] DONE_STEPS,
  output logic              DONE_OOR,
  output logic [2:0]        DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PAUSE_ON  = 3'd1,
    S_MOVE      = 3'd2,
    S_GAP       = 3'd3,
    S_PAUSE_OFF = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  // Wide enough for any practical setup/gap/hold length.
  localparam int TW = 16;

  state_e              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                sel_q, sel_d;
  logic                dir_q, dir_d;
  logic                load_q, load_d;
  logic                oor_q, oor_d;
  logic [STEP_W-1:0]   done_steps_q, done_steps_d;
  logic                done_oor_q, done_oor_d;
  logic                oor_sel;

  // Only the flag of the line being moved matters; the other line's flag is ignored.
  assign oor_sel = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

  // State and datapath registers; async reset drops pause and pulses immediately.
  always_ff @(posedge FAB_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      cnt_q        <= '0;
      steps_q      <= '0;
      sel_q        <= 1'b0;
      dir_q        <= 1'b0;
      load_q       <= 1'b0;
      oor_q        <= 1'b0;
      done_steps_q <= '0;
      done_oor_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      steps_q      <= steps_d;
      sel_q        <= sel_d;
      dir_q        <= dir_d;
      load_q       <= load_d;
      oor_q        <= oor_d;
      done_steps_q <= done_steps_d;
      done_oor_q   <= done_oor_d;
    end
  end

  // Next-state logic: pause framing, MOVE/GAP loop with OOR early exit, completion.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    steps_d      = steps_q;
    sel_d        = sel_q;
    dir_d        = dir_q;
    load_d       = load_q;
    oor_d        = oor_q;
    done_steps_d = done_steps_q;
    done_oor_d   = done_oor_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          sel_d   = REQ_SEL;
          dir_d   = REQ_DIR;
          load_d  = REQ_LOAD;
          steps_d = REQ_STEPS;
          cnt_d   = '0;
          oor_d   = 1'b0;
          tmr_d   = '0;
          if (!REQ_LOAD && (REQ_STEPS == '0)) begin
            // Nothing to move: complete without touching the pause.
            state_d      = S_DONE;
            done_steps_d = '0;
            done_oor_d   = 1'b0;
          end else begin
            state_d = S_PAUSE_ON;
          end
        end
      end
      S_PAUSE_ON: begin
        if (tmr_q == TW'(PAUSE_SETUP - 1)) begin
          tmr_d   = '0;
          state_d = S_MOVE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_MOVE: begin
        cnt_d   = cnt_q + STEP_W'(1);
        tmr_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (tmr_q == TW'(MOVE_GAP - 1)) begin
          tmr_d = '0;
          oor_d = oor_q | oor_sel;
          if (load_q || oor_sel || (cnt_q == steps_q)) begin
            state_d = S_PAUSE_OFF;
          end else begin
            state_d = S_MOVE;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_PAUSE_OFF: begin
        if (tmr_q == TW'(PAUSE_HOLD - 1)) begin
          tmr_d        = '0;
          state_d      = S_DONE;
          done_steps_d = load_q ? '0 : cnt_q;
          done_oor_d   = oor_q;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Lane-facing outputs decoded from registered state, so they are glitch-free.
  assign REQ_READY            = (state_q == S_IDLE);
  assign DELAY_LINE_SEL       = sel_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_MOVE      = (state_q == S_MOVE) && !load_q;
  assign DELAY_LINE_LOAD      = (state_q == S_MOVE) && load_q;
  assign HS_IO_CLK_PAUSE      = (state_q == S_PAUSE_ON) || (state_q == S_MOVE) ||
                                (state_q == S_GAP);
  assign DONE                 = (state_q == S_DONE);
  assign DONE_STEPS           = done_steps_q;
  assign DONE_OOR             = done_oor_q;
  assign DBG_STATE            = state_q;

endmodule

// File: tb/tb_lane_dly_move_ctrl.sv
// Bench for lane_dly_move_ctrl: directed cases plus randomized requests, with a
// per-request timeline model built from the pause/move/gap/hold arithmetic.
module tb_lane_dly_move_ctrl;

  localparam int PS = 4;
  localparam int G  = 3;
  localparam int PH = 4;

  logic       FAB_CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_SEL = 1'b0;
  logic       REQ_DIR = 1'b0;
  logic       REQ_LOAD = 1'b0;
  logic [7:0] REQ_STEPS = 8'd0;
  logic       DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, DELAY_LINE_LOAD;
  logic       HS_IO_CLK_PAUSE;
  logic       RX_OOR = 1'b0;
  logic       TX_OOR = 1'b0;
  logic       DONE;
  logic [7:0] DONE_STEPS;
  logic       DONE_OOR;
  logic [2:0] DBG_STATE;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle record: {pause, move, load, done, oor, steps[7:0]}
  logic [12:0] exp_q[$];
  logic        exp_sel = 1'b0;
  logic        exp_dir = 1'b0;
  logic [7:0]  held_steps = 8'd0;
  logic        held_oor = 1'b0;

  lane_dly_move_ctrl #(.PAUSE_SETUP(PS), .MOVE_GAP(G), .PAUSE_HOLD(PH), .STEP_W(8)) dut (
    .FAB_CLK(FAB_CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_SEL(REQ_SEL), .REQ_DIR(REQ_DIR), .REQ_LOAD(REQ_LOAD), .REQ_STEPS(REQ_STEPS),
    .DELAY_LINE_SEL(DELAY_LINE_SEL), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE),
    .RX_DELAY_LINE_OUT_OF_RANGE(RX_OOR), .TX_DELAY_LINE_OUT_OF_RANGE(TX_OOR),
    .DONE(DONE), .DONE_STEPS(DONE_STEPS), .DONE_OOR(DONE_OOR), .DBG_STATE(DBG_STATE)
  );

  // Clock
  always #5 FAB_CLK = ~FAB_CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: one record per busy cycle; idle expectations otherwise.
  always @(negedge FAB_CLK) begin
    logic [12:0] e;
    logic        e_ready;
    if (RESET_N) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        e_ready = 1'b0;
      end else begin
        e = 13'd0;
        e_ready = 1'b1;
      end
      if (e[9]) begin
        held_steps = e[7:0];
        held_oor   = e[8];
      end
      chk("ready", REQ_READY, e_ready);
      chk("pause", HS_IO_CLK_PAUSE, e[12]);
      chk("move", DELAY_LINE_MOVE, e[11]);
      chk("load", DELAY_LINE_LOAD, e[10]);
      chk("done", DONE, e[9]);
      chk("done_steps", DONE_STEPS, held_steps);
      chk("done_oor", DONE_OOR, held_oor);
      chk("sel", DELAY_LINE_SEL, exp_sel);
      chk("dir", DELAY_LINE_DIRECTION, exp_dir);
      chk("pulse_outside_pause", (DELAY_LINE_MOVE | DELAY_LINE_LOAD) & ~HS_IO_CLK_PAUSE, 0);
      chk("move_and_load", DELAY_LINE_MOVE & DELAY_LINE_LOAD, 0);
    end
  end

  task automatic idle_cyc(input int k);
    REQ_VALID = 1'b0;
    repeat (k) begin
      @(posedge FAB_CLK); #1;
    end
  endtask

  // Driver + model. fmode: 0 sparse random flags, 1 RX rises at rise_c,
  // 2 TX held high / RX low, 3 all flags low. abort_at>=0 asserts reset in that cycle.
  task automatic run_req(input logic sel, input logic dir, input logic load,
                         input logic [7:0] steps, input int fmode, input int rise_c,
                         input int abort_at, output int lat, output int rep, output int oor);
    logic rx_a[0:2047];
    logic tx_a[0:2047];
    int   n, pause_len, got, s;
    logic f, pulse;
    lat = 0; rep = 0; oor = 0;
    for (int c = 0; c < 2048; c++) begin
      case (fmode)
        0: begin rx_a[c] = ($urandom_range(0, 11) == 0); tx_a[c] = ($urandom_range(0, 11) == 0); end
        1: begin rx_a[c] = (c >= rise_c); tx_a[c] = 1'b0; end
        2: begin rx_a[c] = 1'b0; tx_a[c] = 1'b1; end
        default: begin rx_a[c] = 1'b0; tx_a[c] = 1'b0; end
      endcase
    end
    // Timeline from the rules: setup, then (pulse + gap) per move, then hold, then DONE.
    if (!load && steps == 8'd0) begin
      lat = 1; n = 0; pause_len = 0;
    end else begin
      n = 0;
      for (int i = 1; i <= 256; i++) begin
        s = PS + (i - 1) * (G + 1) + G;
        f = sel ? tx_a[s] : rx_a[s];
        n = i;
        if (f) oor = 1;
        if (load || f || i == int'(steps)) break;
      end
      pause_len = PS + n * (G + 1);
      lat = pause_len + PH + 1;
    end
    rep = load ? 0 : n;

    REQ_VALID = 1'b1; REQ_SEL = sel; REQ_DIR = dir; REQ_LOAD = load; REQ_STEPS = steps;
    got = 0;
    for (int w = 0; w < 100; w++) begin
      @(negedge FAB_CLK);
      if (REQ_READY) begin got = 1; break; end
    end
    if (got == 0) begin
      chk("ready_timeout", 0, 1);
      REQ_VALID = 1'b0;
      return;
    end
    @(posedge FAB_CLK); #1;
    exp_sel = sel; exp_dir = dir;
    for (int c = 0; c < lat; c++) begin
      pulse = (c >= PS) && (c < pause_len) && (((c - PS) % (G + 1)) == 0);
      exp_q.push_back({(c < pause_len), pulse & ~load, pulse & load, (c == lat - 1),
                       logic'(oor != 0), 8'(rep)});
    end
    for (int c = 0; c < lat; c++) begin
      RX_OOR = rx_a[c]; TX_OOR = tx_a[c];
      REQ_VALID = 1'($urandom_range(0, 1)); REQ_SEL = 1'($urandom_range(0, 1));
      REQ_DIR = 1'($urandom_range(0, 1)); REQ_LOAD = 1'($urandom_range(0, 1));
      REQ_STEPS = 8'($urandom_range(0, 255));
      if (c == abort_at) begin
        REQ_VALID = 1'b0;
        RESET_N = 1'b0;
        exp_q.delete();
        held_steps = 8'd0; held_oor = 1'b0; exp_sel = 1'b0; exp_dir = 1'b0;
        #1;
        chk("abort_pause", HS_IO_CLK_PAUSE, 0);
        chk("abort_move", DELAY_LINE_MOVE, 0);
        chk("abort_ready", REQ_READY, 1);
        chk("abort_done", DONE, 0);
        chk("abort_done_steps", DONE_STEPS, 0);
        repeat (2) @(posedge FAB_CLK);
        #1 RESET_N = 1'b1;
        return;
      end
      @(posedge FAB_CLK); #1;
    end
    REQ_VALID = 1'b0;
    RX_OOR = 1'b0; TX_OOR = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rep, oor;
    // Reset state
    #12;
    chk("rst_ready", REQ_READY, 1);
    chk("rst_pause", HS_IO_CLK_PAUSE, 0);
    chk("rst_move", DELAY_LINE_MOVE, 0);
    chk("rst_load", DELAY_LINE_LOAD, 0);
    chk("rst_done", DONE, 0);
    chk("rst_done_steps", DONE_STEPS, 0);
    chk("rst_sel", DELAY_LINE_SEL, 0);
    @(posedge FAB_CLK); #1 RESET_N = 1'b1;
    idle_cyc(3);

    // 1. RX move, 3 steps
    run_req(1'b0, 1'b1, 1'b0, 8'd3, 3, 0, -1, lat, rep, oor);
    chk("t1_latency", lat, 21); chk("t1_steps", rep, 3); chk("t1_oor", oor, 0);
    idle_cyc(2);
    // 2. OOR abort after 2nd pulse (pulse 2 is cycle 8)
    run_req(1'b0, 1'b0, 1'b0, 8'd10, 1, 9, -1, lat, rep, oor);
    chk("t2_latency", lat, 17); chk("t2_steps", rep, 2); chk("t2_oor", oor, 1);
    idle_cyc(2);
    // 3. Load with unselected TX flag held high
    run_req(1'b0, 1'b1, 1'b1, 8'd50, 2, 0, -1, lat, rep, oor);
    chk("t3_latency", lat, 13); chk("t3_steps", rep, 0); chk("t3_oor", oor, 0);
    idle_cyc(1);
    // 4. Zero steps
    run_req(1'b1, 1'b0, 1'b0, 8'd0, 3, 0, -1, lat, rep, oor);
    chk("t4_latency", lat, 1); chk("t4_steps", rep, 0);
    idle_cyc(2);
    // 5. Reset in the GAP of step 2, then a single step
    run_req(1'b1, 1'b1, 1'b0, 8'd5, 3, 0, 10, lat, rep, oor);
    idle_cyc(2);
    run_req(1'b1, 1'b0, 1'b0, 8'd1, 3, 0, -1, lat, rep, oor);
    chk("t5_latency", lat, 13);
    // 6. Back-to-back requests
    run_req(1'b0, 1'b1, 1'b0, 8'd2, 3, 0, -1, lat, rep, oor);
    run_req(1'b1, 1'b1, 1'b0, 8'd3, 0, 0, -1, lat, rep, oor);
    idle_cyc(1);
    // Randomized requests, mixed idle gaps and back-to-back
    for (int k = 0; k < 40; k++) begin
      logic [7:0] st;
      st = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      run_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0), st, 0, 0, -1, lat, rep, oor);
      if ($urandom_range(0, 1) == 1) idle_cyc($urandom_range(1, 3));
    end
    // Full-range step count completes without wrap
    run_req(1'b1, 1'b1, 1'b0, 8'd255, 3, 0, -1, lat, rep, oor);
    chk("max_latency", lat, 1029); chk("max_steps", rep, 255);
    idle_cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
